// File: rtl/data_stack_if.sv
// data_stack_if: operation request and stack status bundle between control and the data stack
interface data_stack_if #(parameter int DEPTH = 16);
    localparam int DW = $clog2(DEPTH) + 1;
    logic [2:0]    stackOP;
    logic [15:0]   stackWriteData;
    logic          errClr;
    logic [15:0]   top;
    logic [15:0]   second;
    logic [DW-1:0] depth;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          underflow;
    modport master (
        output stackOP, stackWriteData, errClr,
        input  top, second, depth, full, empty, overflow, underflow
    );
    modport slave (
        input  stackOP, stackWriteData, errClr,
        output top, second, depth, full, empty, overflow, underflow
    );
endinterface

// File: rtl/data_stack.sv
// data_stack: single-cycle 16-bit operand stack with sticky overflow/underflow flags
module data_stack #(parameter int DEPTH = 16) (
    input logic        CLK,
    input logic        reset,
    data_stack_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [2:0] {NOP, PUSH, POP, REPL, BIN, SWAP, DUP, POP2} op_t;
    logic [15:0] mem [DEPTH];
    logic [AW:0] cnt, cnt_nxt, need;
    logic [AW-1:0] i0, i1, i2, wa;
    logic [15:0] wd;
    logic ovf_q, unf_q, grow, lack, over, go, we, swap;
    op_t op;
    assign op = op_t'(bus.stackOP);
    // i0 is the next free slot, i1 the TOS slot, i2 the NOS slot; wrap is harmless since depth gates use
    assign i0 = cnt[AW-1:0];
    assign i1 = i0 - AW'(1);
    assign i2 = i0 - AW'(2);
    assign grow = op == PUSH || op == DUP;
    assign need = (op == POP || op == REPL || op == DUP) ? (AW+1)'(1) :
                  (op == BIN || op == SWAP || op == POP2) ? (AW+1)'(2) : '0;
    assign lack = cnt < need;
    assign over = grow && cnt == (AW+1)'(DEPTH);
    assign go = !lack && !over;
    // next depth and the single data write (SWAP adds a second write to the NOS slot)
    always_comb begin
        cnt_nxt = grow ? cnt + (AW+1)'(1) :
                  (op == POP || op == BIN) ? cnt - (AW+1)'(1) :
                  op == POP2 ? cnt - (AW+1)'(2) : cnt;
        we = go && (op inside {PUSH, DUP, REPL, BIN, SWAP});
        swap = go && op == SWAP;
        wa = grow ? i0 : op == BIN ? i2 : i1;
        wd = op == DUP ? mem[i1] : op == SWAP ? mem[i2] : bus.stackWriteData;
    end
    // depth and sticky error flags; a fault in the same cycle as errClr wins
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cnt   <= go ? cnt_nxt : cnt;
            ovf_q <= over | (ovf_q & ~bus.errClr);
            unf_q <= lack | (unf_q & ~bus.errClr);
        end
    end
    // entry storage, unreset; stale entries above depth are never shown
    always_ff @(posedge CLK) begin
        if (we) mem[wa] <= wd;
        if (swap) mem[i2] <= mem[i1];
    end
    assign bus.top       = cnt != '0 ? mem[i1] : '0;
    assign bus.second    = cnt > (AW+1)'(1) ? mem[i2] : '0;
    assign bus.depth     = cnt;
    assign bus.full      = cnt == (AW+1)'(DEPTH);
    assign bus.empty     = cnt == '0;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
endmodule

// File: tb/tb_data_stack.sv
// tb_data_stack: directed stimulus against a queue-based stack model, plus literal spot checks
module tb_data_stack;
    localparam int DEPTH = 16;
    logic CLK = 1'b0;
    logic reset = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    logic [15:0] q[$];
    bit m_ovf, m_unf;
    always #5 CLK = ~CLK;
    data_stack_if #(.DEPTH(DEPTH)) bus();
    data_stack #(.DEPTH(DEPTH)) dut (.CLK(CLK), .reset(reset), .bus(bus));

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    function automatic logic [15:0] m_top();
        return q.size() > 0 ? q[q.size()-1] : 16'h0;
    endfunction

    function automatic logic [15:0] m_sec();
        return q.size() > 1 ? q[q.size()-2] : 16'h0;
    endfunction

    function automatic void model_step(input logic [2:0] o, input logic [15:0] d, input logic c);
        int need;
        bit so, su;
        logic [15:0] a, b;
        need = (o == 2 || o == 3 || o == 6) ? 1 : (o == 4 || o == 5 || o == 7) ? 2 : 0;
        so = 0;
        su = 0;
        if (q.size() < need) su = 1;
        else if ((o == 1 || o == 6) && q.size() == DEPTH) so = 1;
        else begin
            case (o)
                3'd1: q.push_back(d);
                3'd2: void'(q.pop_back());
                3'd3: q[q.size()-1] = d;
                3'd4: begin void'(q.pop_back()); q[q.size()-1] = d; end
                3'd5: begin a = q.pop_back(); b = q.pop_back(); q.push_back(a); q.push_back(b); end
                3'd6: begin a = q[q.size()-1]; q.push_back(a); end
                3'd7: begin void'(q.pop_back()); void'(q.pop_back()); end
                default: ;
            endcase
        end
        m_ovf = so | (m_ovf & !c);
        m_unf = su | (m_unf & !c);
    endfunction

    always @(posedge CLK or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_ovf = 0;
            m_unf = 0;
        end else model_step(bus.stackOP, bus.stackWriteData, bus.errClr);
    end

    always @(negedge CLK) begin
        chk("m_top", bus.top, m_top());
        chk("m_second", bus.second, m_sec());
        chk("m_depth", bus.depth, q.size());
        chk("m_full", bus.full, q.size() == DEPTH);
        chk("m_empty", bus.empty, q.size() == 0);
        chk("m_overflow", bus.overflow, m_ovf);
        chk("m_underflow", bus.underflow, m_unf);
    end

    task automatic op(input logic [2:0] o, input logic [15:0] d, input logic c);
        @(negedge CLK);
        bus.stackOP = o;
        bus.stackWriteData = d;
        bus.errClr = c;
        @(posedge CLK);
        #1;
        bus.stackOP = 3'd0;
        bus.stackWriteData = 16'h0;
        bus.errClr = 1'b0;
    endtask

    initial begin
        bus.stackOP = 3'd0;
        bus.stackWriteData = 16'h0;
        bus.errClr = 1'b0;
        #2;
        chk("rst_depth", bus.depth, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_top", bus.top, 0);
        chk("rst_full", bus.full, 0);
        @(negedge CLK);
        reset = 1'b1;
        op(3'd1, 16'h0011, 0);
        op(3'd1, 16'h0022, 0);
        chk("push_top", bus.top, 16'h0022);
        chk("push_second", bus.second, 16'h0011);
        chk("push_depth", bus.depth, 2);
        chk("push_empty", bus.empty, 0);
        op(3'd4, 16'h0033, 0);
        chk("bin_top", bus.top, 16'h0033);
        chk("bin_second", bus.second, 16'h0000);
        chk("bin_depth", bus.depth, 1);
        op(3'd5, 16'h0000, 0);
        chk("swap_unf", bus.underflow, 1);
        chk("swap_unf_top", bus.top, 16'h0033);
        op(3'd0, 16'h0000, 1);
        chk("clr_unf", bus.underflow, 0);
        op(3'd2, 16'h0000, 0);
        for (int i = 0; i < 16; i++) op(3'd1, 16'(16'h0100 + i), 0);
        chk("full_flag", bus.full, 1);
        chk("full_top", bus.top, 16'h010F);
        op(3'd1, 16'hFFFF, 0);
        chk("ovf_flag", bus.overflow, 1);
        chk("ovf_top", bus.top, 16'h010F);
        chk("ovf_depth", bus.depth, 16);
        op(3'd6, 16'h0000, 1);
        chk("ovf_set_wins", bus.overflow, 1);
        for (int i = 0; i < 16; i++) op(3'd2, 16'h0000, 0);
        chk("drain_empty", bus.empty, 1);
        chk("drain_top", bus.top, 16'h0000);
        op(3'd0, 16'h0000, 1);
        chk("clr_ovf", bus.overflow, 0);
        op(3'd1, 16'h000A, 0);
        op(3'd1, 16'h000B, 0);
        op(3'd5, 16'h0000, 0);
        chk("swap_top", bus.top, 16'h000A);
        chk("swap_second", bus.second, 16'h000B);
        op(3'd6, 16'h0000, 0);
        chk("dup_top", bus.top, 16'h000A);
        chk("dup_second", bus.second, 16'h000A);
        chk("dup_depth", bus.depth, 3);
        op(3'd7, 16'h0000, 0);
        chk("pop2_top", bus.top, 16'h000B);
        chk("pop2_depth", bus.depth, 1);
        op(3'd3, 16'h7FFF, 0);
        chk("repl_top", bus.top, 16'h7FFF);
        chk("repl_depth", bus.depth, 1);
        op(3'd7, 16'h0000, 0);
        chk("pop2_unf", bus.underflow, 1);
        chk("pop2_unf_depth", bus.depth, 1);
        op(3'd0, 16'h0000, 1);
        op(3'd2, 16'h0000, 0);
        op(3'd2, 16'h0000, 1);
        chk("pop_clr_unf", bus.underflow, 1);
        op(3'd0, 16'h0000, 1);
        chk("nop_clr_unf", bus.underflow, 0);
        op(3'd1, 16'h0001, 0);
        op(3'd1, 16'h0002, 0);
        op(3'd1, 16'h0003, 0);
        chk("pre_rst_depth", bus.depth, 3);
        @(negedge CLK);
        #2;
        reset = 1'b0;
        #1;
        chk("async_depth", bus.depth, 0);
        chk("async_top", bus.top, 0);
        chk("async_empty", bus.empty, 1);
        bus.stackOP = 3'd1;
        bus.stackWriteData = 16'h0009;
        @(posedge CLK);
        #1;
        chk("held_rst_depth", bus.depth, 0);
        bus.stackOP = 3'd0;
        bus.stackWriteData = 16'h0;
        @(negedge CLK);
        reset = 1'b1;
        op(3'd1, 16'h0005, 0);
        chk("post_rst_top", bus.top, 16'h0005);
        chk("post_rst_depth", bus.depth, 1);
        @(negedge CLK);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
